// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state type, datapath widths and default parameters for neuron_seq
package neuron_pkg;
  localparam int PIX_W = 8;
  localparam int LANES = 16;
  localparam int DATA_W = PIX_W * LANES;
  localparam int SUM_W = 20;
  localparam int BIAS_W = 16;
  localparam int N_CHUNKS_DEF = 49;
  localparam int MAC_LAT_DEF = 6;
  localparam int ADDR_W_DEF = 6;
  localparam int ACC_W_DEF = 28;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_BIAS} state_t;
endpackage

// File: rtl/neuron_seq_if.sv
// neuron_seq_if: memory read port and MAC operand/sum bus between neuron_seq and its memories/MAC
//   master (sequencer): drives mem_en, mem_addr, pixels_mac, weights_mac; reads pixels_rd, weights_rd, sum_mac
//   slave  (memories/MAC): the reverse
interface neuron_seq_if #(parameter int ADDR_W = neuron_pkg::ADDR_W_DEF);
  import neuron_pkg::*;
  logic mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] pixels_rd, weights_rd, pixels_mac, weights_mac;
  logic [SUM_W-1:0] sum_mac;
  modport master(output mem_en, mem_addr, pixels_mac, weights_mac, input pixels_rd, weights_rd, sum_mac);
  modport slave(input mem_en, mem_addr, pixels_mac, weights_mac, output pixels_rd, weights_rd, sum_mac);
endinterface

// File: rtl/neuron_vpipe.sv
// neuron_vpipe: DEPTH-stage 1-bit valid shift register with asynchronous clear
//   clk, rst (async, active-high); din enters stage 0; q[DEPTH-1] is the tail
module neuron_vpipe #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic [DEPTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= {q[DEPTH-2:0], din};
endmodule

// File: rtl/neuron_seq.sv
// neuron_seq: sequences one neuron evaluation (memory reads, MAC operands, accumulate, bias)
//   clk, rst (async, active-high)
//   start, bias: launch an evaluation from IDLE with a signed 16-bit bias
//   busy: high outside IDLE; done: one-cycle pulse with result valid; result: signed, held
//   bus (neuron_seq_if.master): memory read strobe/address/data, MAC operands and sum
//   NEURON_SEQ_RELU_EN: when defined, negative results are clamped to zero
module neuron_seq import neuron_pkg::*; #(
  parameter int N_CHUNKS = N_CHUNKS_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic signed [BIAS_W-1:0] bias,
  output logic busy,
  output logic done,
  output logic signed [ACC_W-1:0] result,
  neuron_seq_if.master bus
);
  localparam int DEPTH = MAC_LAT + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CHUNKS - 1);
  state_t state, state_n;
  logic go;
  logic [DEPTH-1:0] vld;
  logic signed [ACC_W-1:0] acc, sum_b, res_n;
  logic signed [BIAS_W-1:0] bias_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // DRAIN ends on the cycle the last tagged sum sits at the tail; it is added on the same edge
  always_comb begin
    go = state == S_IDLE && start;
    state_n = go ? S_ISSUE :
              state == S_ISSUE && bus.mem_addr == LAST ? S_DRAIN :
              state == S_DRAIN && ~|vld[DEPTH-2:0] ? S_BIAS :
              state == S_BIAS ? S_IDLE : state;
    bus.mem_en = state == S_ISSUE;
    busy = state != S_IDLE;
  end
  // stage 0 doubles as the delayed read strobe marking valid memory data
  neuron_vpipe #(.DEPTH(DEPTH)) u_vpipe (.clk, .rst, .din(bus.mem_en), .q(vld));
  assign sum_b = acc + ACC_W'(bias_q);
`ifdef NEURON_SEQ_RELU_EN
  assign res_n = sum_b[ACC_W-1] ? '0 : sum_b;
`else
  assign res_n = sum_b;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.mem_addr <= '0;
      bus.pixels_mac <= '0;
      bus.weights_mac <= '0;
      acc <= '0;
      bias_q <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= state == S_BIAS;
      bus.pixels_mac <= vld[0] ? bus.pixels_rd : '0;
      bus.weights_mac <= vld[0] ? bus.weights_rd : '0;
      if (go) begin
        bus.mem_addr <= '0;
        acc <= '0;
        bias_q <= bias;
      end else begin
        if (state == S_ISSUE) bus.mem_addr <= bus.mem_addr == LAST ? '0 : bus.mem_addr + 1'b1;
        if (vld[DEPTH-1]) acc <= acc + ACC_W'(bus.sum_mac);
      end
      if (state == S_BIAS) result <= res_n;
    end
endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: scoreboard bench for neuron_seq (default build and a single-chunk build)
module tb_neuron_seq;
  import neuron_pkg::*;
  typedef struct {
    logic signed [27:0] res;
    int s;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic signed [15:0] bias = '0;
  logic busy0, done0, busy1, done1;
  logic signed [27:0] res0, res1;
  logic [7:0] pix = '0, wt = '0;
  logic [19:0] m0 [6];
  logic [19:0] m1 [6];
  int cyc = 0, checks = 0, errors = 0, ea0 = 0, ea1 = 0;
  exp_t q0[$], q1[$];
  exp_t e;
  neuron_seq_if #(.ADDR_W(6)) b0 ();
  neuron_seq_if #(.ADDR_W(6)) b1 ();
  neuron_seq dut0 (.clk(clk), .rst(rst), .start(start0), .bias(bias), .busy(busy0), .done(done0), .result(res0), .bus(b0));
  neuron_seq #(.N_CHUNKS(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .bias(bias), .busy(busy1), .done(done1), .result(res1), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [19:0] mac(input logic [127:0] p, input logic [127:0] w);
    logic [19:0] s = '0;
    for (int i = 0; i < 16; i++) s += 20'(p[i*8+:8]) * 20'(w[i*8+:8]);
    return s;
  endfunction
  function automatic logic signed [27:0] relu(input logic signed [27:0] x);
`ifdef NEURON_SEQ_RELU_EN
    return x < 0 ? '0 : x;
`else
    return x;
`endif
  endfunction
  always @(posedge clk) begin
    b0.pixels_rd <= b0.mem_en ? {16{pix}} : {16{8'hA5}};
    b0.weights_rd <= b0.mem_en ? {16{wt}} : {16{8'h5A}};
    b1.pixels_rd <= b1.mem_en ? {16{pix}} : {16{8'hA5}};
    b1.weights_rd <= b1.mem_en ? {16{wt}} : {16{8'h5A}};
    m0[0] <= mac(b0.pixels_mac, b0.weights_mac);
    m1[0] <= mac(b1.pixels_mac, b1.weights_mac);
    for (int k = 1; k < 6; k++) begin
      m0[k] <= m0[k-1];
      m1[k] <= m1[k-1];
    end
  end
  assign b0.sum_mac = m0[5];
  assign b1.sum_mac = m1[5];
  task automatic check(input string nm, input longint act, input longint ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask
  task automatic unexp(input string nm, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected done, result %0d, expected no done", nm, act);
  endtask
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) unexp("dut0", res0);
      else begin
        e = q0.pop_front();
        check("dut0 result", res0, e.res);
        check("dut0 latency", cyc - e.s + 1, 59);
      end
    end
    if (done1) begin
      if (q1.size() == 0) unexp("dut1", res1);
      else begin
        e = q1.pop_front();
        check("dut1 result", res1, e.res);
        check("dut1 latency", cyc - e.s + 1, 11);
      end
    end
    if (b0.mem_en) begin
      check("dut0 mem_addr", b0.mem_addr, ea0);
      ea0++;
    end else ea0 = 0;
    if (b1.mem_en) begin
      check("dut1 mem_addr", b1.mem_addr, ea1);
      ea1++;
    end else ea1 = 0;
  end
  task automatic run(input int d, input logic [7:0] p, input logic [7:0] w, input logic signed [15:0] b, input logic signed [27:0] er);
    pix = p;
    wt = w;
    bias = b;
    if (d == 0) begin
      start0 = 1'b1;
      q0.push_back('{er, cyc + 1});
    end else begin
      start1 = 1'b1;
      q1.push_back('{er, cyc + 1});
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    bias = 16'sh1234;
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (q0.size() == 0 && q1.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout, done not seen within 200 cycles", nm);
    q0.delete();
    q1.delete();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset result", res0, 0);
    check("reset mem_en", b0.mem_en, 0);
    check("reset mem_addr", b0.mem_addr, 0);
    check("reset pixels_mac", b0.pixels_mac, 0);
    check("reset weights_mac", b0.weights_mac, 0);
    rst = 1'b0;
    @(negedge clk);
    run(0, 8'h01, 8'h02, 16'sd0, 28'sd1568);
    drain("basic");
    run(0, 8'hFF, 8'hFF, 16'sd0, 28'sd50979600);
    drain("max");
    run(0, 8'h00, 8'h55, -16'sd100, relu(-28'sd100));
    drain("neg bias");
    run(0, 8'h01, 8'h02, 16'sd1000, 28'sd2568);
    drain("pos bias");
    run(0, 8'h01, 8'h02, -16'sd2000, relu(-28'sd432));
    drain("neg sum");
    run(0, 8'hFF, 8'hFF, -16'sd32768, 28'sd50946832);
    drain("min bias");
    run(0, 8'h00, 8'h00, 16'sd32767, 28'sd32767);
    drain("max bias");
    run(0, 8'h01, 8'h02, 16'sd0, 28'sd1568);
    repeat (9) @(negedge clk);
    check("busy mid-run", busy0, 1);
    start0 = 1'b1;
    bias = -16'sd5;
    @(negedge clk);
    start0 = 1'b0;
    drain("start while busy");
    run(0, 8'h01, 8'h02, 16'sd0, 28'sd1568);
    for (int i = 0; i < 200 && !done0; i++) @(negedge clk);
    run(0, 8'h02, 8'h03, -16'sd7, 28'sd4697);
    drain("back-to-back");
    run(0, 8'h01, 8'h02, 16'sd0, 28'sd1568);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    #1;
    check("abort busy", busy0, 0);
    check("abort mem_en", b0.mem_en, 0);
    check("abort result", res0, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 8'h01, 8'h02, 16'sd0, 28'sd1568);
    drain("restart");
    run(1, 8'h03, 8'h04, 16'sd5, 28'sd197);
    drain("single chunk");
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
